// File: rtl/inst_fetch_resp_pkg.sv
// Shared types and constants for the instruction fetch responder.
package inst_fetch_resp_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD   = '0;
  localparam logic              CHIP_ENABLE = 1'b1;
  localparam logic              FLUSH       = 1'b1;
  localparam logic              STOP        = 1'b1;
  localparam logic              NO_STOP     = 1'b0;

  typedef enum logic [1:0] {
    IF_IDLE    = 2'd0,
    IF_REQ     = 2'd1,
    IF_DISCARD = 2'd2
  } if_state_e;

endpackage

// File: rtl/inst_fetch_resp_line_buf.sv
// One-entry instruction line buffer: registered fill, combinational tag lookup.
module inst_line_buf
  import inst_fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_fill,
  input  logic [ADDR_W-3:0] i_fill_tag,
  input  logic [DATA_W-1:0] i_fill_data,
  input  logic              i_ce,
  input  logic [ADDR_W-3:0] i_tag,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [ADDR_W-3:0] r_tag;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_data  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_data  <= i_fill_data;
    end
  end

  always_comb begin
    o_hit  = (i_ce == CHIP_ENABLE) && r_valid && (r_tag == i_tag);
    o_data = r_data;
  end

endmodule

// File: rtl/inst_fetch_resp.sv
// Fetch responder: serves pc from the line buffer, refills it from memory over req/ack.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_W,
  parameter int unsigned DATA_W = INST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] inst,
  output logic              stallreq,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  if_state_e         r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              w_hit;
  logic [DATA_W-1:0] w_buf_data;
  logic              w_fill;

  assign w_fill = (r_state == IF_REQ) && mem_ack && (flush != FLUSH);

  inst_line_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_line_buf (
    .clk         (clk),
    .rst         (rst),
    .i_fill      (w_fill),
    .i_fill_tag  (r_mem_addr[ADDR_W-1:2]),
    .i_fill_data (mem_rdata),
    .i_ce        (ce),
    .i_tag       (pc[ADDR_W-1:2]),
    .o_hit       (w_hit),
    .o_data      (w_buf_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IF_IDLE;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      case (r_state)
        IF_IDLE: begin
          if ((ce == CHIP_ENABLE) && !w_hit && (flush != FLUSH)) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {pc[ADDR_W-1:2], 2'b00};
            r_state    <= IF_REQ;
          end
        end
        IF_REQ: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IF_IDLE;
          end else if (flush == FLUSH) begin
            r_state <= IF_DISCARD;
          end
        end
        IF_DISCARD: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IF_IDLE;
          end
        end
        default: begin
          r_mem_req <= 1'b0;
          r_state   <= IF_IDLE;
        end
      endcase
    end
  end

  // Reset gates stallreq so a held ce does not stall the pipe while the buffer is cleared.
  always_comb begin
    inst     = w_hit ? w_buf_data : ZERO_WORD;
    stallreq = ((ce == CHIP_ENABLE) && !w_hit && !rst) ? STOP : NO_STOP;
  end

  assign mem_req  = r_mem_req;
  assign mem_addr = r_mem_addr;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp: each cycle's outputs checked against hand-computed values.
module tb_inst_fetch_resp;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [31:0] pc;
  logic        flush;
  logic [31:0] inst;
  logic        stallreq;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  inst_fetch_resp #(
    .ADDR_W (32),
    .DATA_W (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .pc        (pc),
    .flush     (flush),
    .inst      (inst),
    .stallreq  (stallreq),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Let combinational outputs settle after the inputs change, then check all four outputs.
  task automatic expect_out(input string tag, input logic e_req, input logic [31:0] e_addr,
                            input logic e_stall, input logic [31:0] e_inst);
    #2;
    chk({tag, ".mem_req"},  {31'b0, mem_req},  {31'b0, e_req});
    chk({tag, ".mem_addr"}, mem_addr,          e_addr);
    chk({tag, ".stallreq"}, {31'b0, stallreq}, {31'b0, e_stall});
    chk({tag, ".inst"},     inst,              e_inst);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; pc = '0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    expect_out("reset", 1'b0, 32'h0, 1'b0, 32'h0);
    ce = 1'b1;
    expect_out("reset_ce", 1'b0, 32'h0, 1'b0, 32'h0);

    // First fetch at pc 0, acked in the first request cycle
    tick(); rst = 1'b0; pc = 32'h0;
    expect_out("t1_c0", 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h3401_1100;
    expect_out("t1_c1", 1'b1, 32'h0, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0;
    expect_out("t1_c2", 1'b0, 32'h0, 1'b0, 32'h3401_1100);

    // Fill word 0x4, then same-word hit at 0x6
    pc = 32'h4;
    expect_out("t2_miss", 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hAAAA_0004;
    expect_out("t2_req", 1'b1, 32'h4, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0; pc = 32'h6;
    expect_out("t2_hit", 1'b0, 32'h4, 1'b0, 32'hAAAA_0004);
    tick();
    expect_out("t2_hold", 1'b0, 32'h4, 1'b0, 32'hAAAA_0004);

    // Miss at 0x100 with a 3-cycle ack delay
    pc = 32'h100;
    expect_out("t3_c0", 1'b0, 32'h4, 1'b1, 32'h0);
    tick(); expect_out("t3_w1", 1'b1, 32'h100, 1'b1, 32'h0);
    tick(); expect_out("t3_w2", 1'b1, 32'h100, 1'b1, 32'h0);
    tick(); expect_out("t3_w3", 1'b1, 32'h100, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hBBBB_0100;
    expect_out("t3_ack", 1'b1, 32'h100, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0;
    expect_out("t3_hit", 1'b0, 32'h100, 1'b0, 32'hBBBB_0100);

    // Flush in IDLE: no request issued, buffer kept
    pc = 32'h180; flush = 1'b1;
    expect_out("fi_c0", 1'b0, 32'h100, 1'b1, 32'h0);
    tick(); pc = 32'h100;
    expect_out("fi_keep", 1'b0, 32'h100, 1'b0, 32'hBBBB_0100);
    tick(); flush = 1'b0;

    // Miss at 0x200 abandoned by flush, passes through DISCARD
    pc = 32'h200;
    expect_out("t4_c0", 1'b0, 32'h100, 1'b1, 32'h0);
    tick(); flush = 1'b1;
    expect_out("t4_flush", 1'b1, 32'h200, 1'b1, 32'h0);
    tick(); flush = 1'b0;
    expect_out("t4_disc", 1'b1, 32'h200, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    expect_out("t4_dack", 1'b1, 32'h200, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0; pc = 32'h100;
    expect_out("t4_old", 1'b0, 32'h200, 1'b0, 32'hBBBB_0100);
    tick(); pc = 32'h200;
    expect_out("t4_remiss", 1'b0, 32'h200, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hCCCC_0200;
    expect_out("t4_req2", 1'b1, 32'h200, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0;
    expect_out("t4_hit", 1'b0, 32'h200, 1'b0, 32'hCCCC_0200);

    // Back-to-back misses: pc moves during REQ, one-cycle req gap afterwards
    pc = 32'h300;
    expect_out("bb_c0", 1'b0, 32'h200, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h1111_0300; pc = 32'h304;
    expect_out("bb_ack", 1'b1, 32'h300, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0;
    expect_out("bb_gap", 1'b0, 32'h300, 1'b1, 32'h0);
    tick();
    expect_out("bb_req2", 1'b1, 32'h304, 1'b1, 32'h0);

    // Asynchronous reset in the middle of REQ
    #2 rst = 1'b1;
    expect_out("t5_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); rst = 1'b0; pc = 32'h0;
    expect_out("t5_miss", 1'b0, 32'h0, 1'b1, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'h3401_1100;
    expect_out("t5_req", 1'b1, 32'h0, 1'b1, 32'h0);
    tick(); mem_ack = 1'b0;
    expect_out("t5_hit", 1'b0, 32'h0, 1'b0, 32'h3401_1100);

    // ce low with a stale miss pc; stray ack in IDLE ignored
    ce = 1'b0; pc = 32'h400;
    expect_out("t6_ce0", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    expect_out("t6_stray", 1'b0, 32'h0, 1'b0, 32'h0);
    tick(); mem_ack = 1'b0; ce = 1'b1; pc = 32'h0;
    expect_out("t6_keep", 1'b0, 32'h0, 1'b0, 32'h3401_1100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
